// File: rtl/demux4.sv
// demux4: one-input, four-output AXI-Stream packet router. The first flit of a
// packet picks the output from TDATA[1:0]; the choice is held until TLAST.
//
// Handshake: a flit moves on a port only in a cycle where both VALID and READY
// are high at the rising edge. s_TREADY is derived from the routing select and
// the selected output only, never from s_TVALID, and a presented flit's
// TDATA/TLAST stay stable until accepted.
module demux4 #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIPE_STAGE  = 1,
    parameter int PACKET_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    input  logic                  s_TLAST,
    output logic [DATA_WIDTH-1:0] o0_TDATA,
    output logic                  o0_TVALID,
    input  logic                  o0_TREADY,
    output logic                  o0_TLAST,
    output logic [DATA_WIDTH-1:0] o1_TDATA,
    output logic                  o1_TVALID,
    input  logic                  o1_TREADY,
    output logic                  o1_TLAST,
    output logic [DATA_WIDTH-1:0] o2_TDATA,
    output logic                  o2_TVALID,
    input  logic                  o2_TREADY,
    output logic                  o2_TLAST,
    output logic [DATA_WIDTH-1:0] o3_TDATA,
    output logic                  o3_TVALID,
    input  logic                  o3_TREADY,
    output logic                  o3_TLAST,
    output logic                  dbg_state
);

    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      dest_q, dest_d;
    logic [1:0]                      sel;
    logic                            s_fire;
    logic [3:0]                      o_ready;
    logic [3:0]                      o_valid;
    logic [3:0]                      o_last;
    logic [3:0][DATA_WIDTH-1:0]      o_data;

    assign o_ready = {o3_TREADY, o2_TREADY, o1_TREADY, o0_TREADY};
    assign s_fire  = s_TVALID & s_TREADY;

    // Body flits follow the locked destination; their own low bits are payload.
    assign sel = (PACKET_MODE != 0 && state_q == BODY) ? dest_q : s_TDATA[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HEAD;
            dest_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        if (PACKET_MODE != 0 && s_fire) begin
            case (state_q)
                HEAD: begin
                    if (!s_TLAST) begin
                        state_d = BODY;
                        dest_d  = s_TDATA[1:0];
                    end
                end
                BODY: begin
                    if (s_TLAST) begin
                        state_d = HEAD;
                    end
                end
                default: state_d = HEAD;
            endcase
        end
    end

    assign dbg_state = state_q;

    if (PIPE_STAGE != 0) begin : g_pipe
        logic [3:0]                 v_q;
        logic [3:0]                 l_q;
        logic [3:0][DATA_WIDTH-1:0] d_q;

        // A full register still accepts when it drains in the same cycle.
        assign s_TREADY = ~v_q[sel] | o_ready[sel];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= '0;
                l_q <= '0;
                d_q <= '0;
            end else begin
                for (int n = 0; n < 4; n++) begin
                    if (s_fire && sel == 2'(n)) begin
                        v_q[n] <= 1'b1;
                        d_q[n] <= s_TDATA;
                        l_q[n] <= s_TLAST;
                    end else if (v_q[n] && o_ready[n]) begin
                        v_q[n] <= 1'b0;
                    end
                end
            end
        end

        assign o_valid = v_q;
        assign o_last  = l_q;
        assign o_data  = d_q;
    end else begin : g_comb
        // Outputs are forced low while reset is asserted.
        assign s_TREADY = rst & o_ready[sel];

        always_comb begin
            o_valid = '0;
            o_last  = '0;
            o_data  = '0;
            for (int n = 0; n < 4; n++) begin
                o_valid[n] = rst & s_TVALID & (sel == 2'(n));
                o_last[n]  = rst & s_TLAST;
                o_data[n]  = rst ? s_TDATA : '0;
            end
        end
    end

    assign o0_TVALID = o_valid[0];
    assign o1_TVALID = o_valid[1];
    assign o2_TVALID = o_valid[2];
    assign o3_TVALID = o_valid[3];
    assign o0_TDATA  = o_data[0];
    assign o1_TDATA  = o_data[1];
    assign o2_TDATA  = o_data[2];
    assign o3_TDATA  = o_data[3];
    assign o0_TLAST  = o_last[0];
    assign o1_TLAST  = o_last[1];
    assign o2_TLAST  = o_last[2];
    assign o3_TLAST  = o_last[3];

endmodule

// File: tb/tb_demux4.sv
// tb_demux4: directed vector table on the registered packet-mode router, then
// a randomized round-robin source model against three parameterisations.
module tb_demux4;

    localparam int DW = 16;
    localparam int NV = 26;
    localparam int RAND_CYCLES = 1500;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus, per-instance outputs ----------------
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic [3:0]    rdy;

    logic          sready [3];
    logic          dbg    [3];
    logic [DW-1:0] od     [3][4];
    logic          ov     [3][4];
    logic          ol     [3][4];

    int cfg = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        demux4 #(
            .DATA_WIDTH (DW),
            .PIPE_STAGE ((g == 1) ? 0 : 1),
            .PACKET_MODE((g == 2) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .s_TDATA  (s_data),
            .s_TVALID (s_valid),
            .s_TREADY (sready[g]),
            .s_TLAST  (s_last),
            .o0_TDATA (od[g][0]),
            .o0_TVALID(ov[g][0]),
            .o0_TREADY(rdy[0]),
            .o0_TLAST (ol[g][0]),
            .o1_TDATA (od[g][1]),
            .o1_TVALID(ov[g][1]),
            .o1_TREADY(rdy[1]),
            .o1_TLAST (ol[g][1]),
            .o2_TDATA (od[g][2]),
            .o2_TVALID(ov[g][2]),
            .o2_TREADY(rdy[2]),
            .o2_TLAST (ol[g][2]),
            .o3_TDATA (od[g][3]),
            .o3_TVALID(ov[g][3]),
            .o3_TREADY(rdy[3]),
            .o3_TLAST (ol[g][3]),
            .dbg_state(dbg[g])
        );
    end

    logic          cur_sready;
    logic          cur_dbg;
    logic [DW-1:0] cur_od [4];
    logic          cur_ov [4];
    logic          cur_ol [4];

    always_comb begin
        cur_sready = sready[cfg];
        cur_dbg    = dbg[cfg];
        for (int n = 0; n < 4; n++) begin
            cur_od[n] = od[cfg][n];
            cur_ov[n] = ov[cfg][n];
            cur_ol[n] = ol[cfg][n];
        end
    end

    function automatic logic [3:0] ov_bits();
        return {cur_ov[3], cur_ov[2], cur_ov[1], cur_ov[0]};
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q [4][$];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic            vld;
        logic [7:0]      data;
        logic            last;
        logic [3:0]      rdy;
        logic            exp_sready;
        logic [3:0]      exp_ov;
        logic [3:0][7:0] exp_od;
        logic [3:0]      exp_ol;
    } vec_t;

    vec_t vecs [NV];
    vec_t v;

    function automatic vec_t mk(input logic vld, input logic [7:0] data, input logic last,
                                input logic [3:0] r, input logic sr, input logic [3:0] eov,
                                input logic [31:0] eod, input logic [3:0] eol);
        vec_t t;
        t.vld = vld; t.data = data; t.last = last; t.rdy = r;
        t.exp_sready = sr; t.exp_ov = eov; t.exp_od = eod; t.exp_ol = eol;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pulse_reset();
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b0;
        #2;
        rst     = 1'b1;
    endtask

    // Upstream round-robin model: per-source tagged, increasing sequence numbers.
    logic [13:0] seq [4];
    int          cur_src;
    int          rr_ptr;
    bit          presenting;
    bit          locked;
    bit          draining;
    int          n_acc;
    logic [3:0]  req;
    bit          found;
    logic [DW:0] e;

    task automatic start_flit();
        s_data     = {seq[cur_src], 2'(cur_src)};
        s_last     = ($urandom_range(0, 2) == 0);
        presenting = 1'b1;
    endtask

    task automatic rand_cycle();
        @(negedge clk);
        if (!presenting && !draining) begin
            if (locked) begin
                if ($urandom_range(0, 3) != 0) start_flit();
            end else begin
                req   = 4'($urandom_range(0, 15));
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && req[(rr_ptr + k) % 4]) begin
                        found   = 1'b1;
                        cur_src = (rr_ptr + k) % 4;
                    end
                end
                if (found) begin
                    rr_ptr = cur_src;
                    start_flit();
                end
            end
        end
        s_valid = presenting;
        rdy     = draining ? 4'hF : (4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)));
        #1;
        if (s_valid && cur_sready) begin
            exp_q[s_data[1:0]].push_back({s_last, s_data});
            seq[cur_src]++;
            presenting = 1'b0;
            locked     = !s_last;
            n_acc++;
        end
        for (int n = 0; n < 4; n++) begin
            if (cur_ov[n] && rdy[n]) begin
                if (exp_q[n].size() == 0) begin
                    check_val($sformatf("cfg%0d_o%0d_unexpected_flit", cfg, n), 32'(cur_od[n]), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[n].pop_front();
                    check_val($sformatf("cfg%0d_o%0d_flit", cfg, n), 32'({cur_ol[n], cur_od[n]}), 32'(e));
                    check_val($sformatf("cfg%0d_o%0d_tag", cfg, n), 32'(cur_od[n][1:0]), 32'(n));
                end
            end
        end
    endtask

    task automatic rand_phase(input int c);
        cfg = c;
        for (int n = 0; n < 4; n++) begin
            exp_q[n].delete();
            seq[n] = 14'd1;
        end
        presenting = 1'b0; locked = 1'b0; draining = 1'b0;
        rr_ptr = 3; n_acc = 0;
        pulse_reset();
        for (int i = 0; i < RAND_CYCLES; i++) rand_cycle();
        draining = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!presenting && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                exp_q[2].size() == 0 && exp_q[3].size() == 0) break;
            rand_cycle();
        end
        check_val($sformatf("cfg%0d_input_stalled", c), 32'(presenting), 32'd0);
        for (int n = 0; n < 4; n++)
            check_val($sformatf("cfg%0d_o%0d_left_in_queue", c, n), 32'(exp_q[n].size()), 32'd0);
        check_val($sformatf("cfg%0d_min_throughput", c), 32'(n_acc > 200), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; rdy = 4'hF;

        vecs[0]  = mk(1, 8'h04, 1, 4'hF, 1, 4'b0000, 32'h0000_0000, 4'b0000);
        vecs[1]  = mk(1, 8'h05, 1, 4'hF, 1, 4'b0001, 32'h0000_0004, 4'b0001);
        vecs[2]  = mk(1, 8'h06, 1, 4'hF, 1, 4'b0010, 32'h0000_0500, 4'b0010);
        vecs[3]  = mk(1, 8'h07, 1, 4'hF, 1, 4'b0100, 32'h0006_0000, 4'b0100);
        vecs[4]  = mk(0, 8'h00, 0, 4'hF, 1, 4'b1000, 32'h0700_0000, 4'b1000);
        vecs[5]  = mk(0, 8'h00, 0, 4'hF, 1, 4'b0000, 32'h0000_0000, 4'b0000);
        vecs[6]  = mk(1, 8'h02, 0, 4'hF, 1, 4'b0000, 32'h0000_0000, 4'b0000);
        vecs[7]  = mk(1, 8'h11, 0, 4'hF, 1, 4'b0100, 32'h0002_0000, 4'b0000);
        vecs[8]  = mk(1, 8'h20, 1, 4'hF, 1, 4'b0100, 32'h0011_0000, 4'b0000);
        vecs[9]  = mk(1, 8'h03, 1, 4'hF, 1, 4'b0100, 32'h0020_0000, 4'b0100);
        vecs[10] = mk(0, 8'h00, 0, 4'hF, 1, 4'b1000, 32'h0300_0000, 4'b1000);
        vecs[11] = mk(0, 8'h00, 0, 4'hF, 1, 4'b0000, 32'h0000_0000, 4'b0000);
        vecs[12] = mk(1, 8'h01, 1, 4'hD, 1, 4'b0000, 32'h0000_0000, 4'b0000);
        vecs[13] = mk(1, 8'h05, 1, 4'hD, 0, 4'b0010, 32'h0000_0100, 4'b0010);
        vecs[14] = mk(1, 8'h05, 1, 4'hD, 0, 4'b0010, 32'h0000_0100, 4'b0010);
        vecs[15] = mk(1, 8'h05, 1, 4'hF, 1, 4'b0010, 32'h0000_0100, 4'b0010);
        vecs[16] = mk(1, 8'h00, 1, 4'hF, 1, 4'b0010, 32'h0000_0500, 4'b0010);
        vecs[17] = mk(0, 8'h00, 0, 4'hF, 1, 4'b0001, 32'h0000_0000, 4'b0001);
        vecs[18] = mk(0, 8'h00, 0, 4'hF, 1, 4'b0000, 32'h0000_0000, 4'b0000);
        vecs[19] = mk(1, 8'h08, 1, 4'hE, 1, 4'b0000, 32'h0000_0000, 4'b0000);
        vecs[20] = mk(1, 8'h09, 1, 4'hE, 1, 4'b0001, 32'h0000_0008, 4'b0001);
        vecs[21] = mk(1, 8'h0D, 1, 4'hE, 1, 4'b0011, 32'h0000_0908, 4'b0011);
        vecs[22] = mk(0, 8'h00, 0, 4'hE, 0, 4'b0011, 32'h0000_0D08, 4'b0011);
        vecs[23] = mk(0, 8'h00, 0, 4'hE, 0, 4'b0001, 32'h0000_0008, 4'b0001);
        vecs[24] = mk(0, 8'h00, 0, 4'hF, 1, 4'b0001, 32'h0000_0008, 4'b0001);
        vecs[25] = mk(0, 8'h00, 0, 4'hF, 1, 4'b0000, 32'h0000_0000, 4'b0000);

        // Reset state
        #12;
        check_val("reset_valid", 32'(ov_bits()), 32'd0);
        check_val("reset_o2_data", 32'(cur_od[2]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("post_reset_sready", 32'(cur_sready), 32'd1);
        check_val("post_reset_state", 32'(cur_dbg), 32'd0);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge clk);
            s_valid = v.vld;
            s_data  = {8'h00, v.data};
            s_last  = v.last;
            rdy     = v.rdy;
            #1;
            check_val($sformatf("vec%0d_sready", i), 32'(cur_sready), 32'(v.exp_sready));
            check_val($sformatf("vec%0d_valid", i), 32'(ov_bits()), 32'(v.exp_ov));
            for (int n = 0; n < 4; n++) begin
                if (v.exp_ov[n]) begin
                    check_val($sformatf("vec%0d_o%0d_data", i, n), 32'(cur_od[n]), {24'h0, v.exp_od[n]});
                    check_val($sformatf("vec%0d_o%0d_last", i, n), 32'(cur_ol[n]), 32'(v.exp_ol[n]));
                end
            end
        end

        // Mid-packet asynchronous reset while locked to output 3
        @(negedge clk);
        s_valid = 1'b1; s_data = 16'h0003; s_last = 1'b0; rdy = 4'hF;
        @(negedge clk);
        s_data = 16'h0004;
        #1;
        check_val("midrst_body_state", 32'(cur_dbg), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check_val("midrst_o3_valid", 32'(ov_bits()), 32'b1000);
        check_val("midrst_o3_data", 32'(cur_od[3]), 32'h0004);
        #1;
        rst = 1'b0;
        #1;
        check_val("midrst_valid_cleared", 32'(ov_bits()), 32'd0);
        check_val("midrst_state_head", 32'(cur_dbg), 32'd0);
        check_val("midrst_o3_data_cleared", 32'(cur_od[3]), 32'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        s_valid = 1'b1; s_data = 16'h0001; s_last = 1'b1;
        #1;
        check_val("midrst_head_sready", 32'(cur_sready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check_val("midrst_route_o1", 32'(ov_bits()), 32'b0010);
        check_val("midrst_o1_data", 32'(cur_od[1]), 32'h0001);

        // Randomized closed loop for each configuration
        rand_phase(0);
        rand_phase(1);
        rand_phase(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
